// File: rtl/fft_input.sv
// Serial complex-sample receiver: four-phase req/ans capture of one N-sample frame
// into a block buffer (optionally bit-reversed), held for the FFT core until released.
module fft_input #(
   parameter int LOG2N  = 3,
   parameter bit BITREV = 1'b1,
   parameter int DW     = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             req_i,
   input  logic [DW-1:0]    data_iR,
   input  logic [DW-1:0]    data_iJ,
   output logic             ans_o,
   output logic             req_o,
   output logic             done_o,
   output logic             full_o,
   input  logic [LOG2N-1:0] rd_addr_i,
   output logic [DW-1:0]    rd_data_oR,
   output logic [DW-1:0]    rd_data_oJ,
   input  logic             release_i
);

   localparam int N = 1 << LOG2N;

   typedef enum logic [1:0] {
      RECV = 2'd0,
      ACK  = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [LOG2N-1:0]   cnt_reg, cnt_next;
   logic               done_reg, done_next;
   logic               wr_en;
   logic [LOG2N-1:0]   cnt_rev;
   logic [LOG2N-1:0]   wr_addr;
   logic [2*DW-1:0]    mem [N];
   logic [DW-1:0]      rd_r_reg, rd_j_reg;

   generate
      for (genvar gi = 0; gi < LOG2N; gi++) begin : g_rev
         assign cnt_rev[gi] = cnt_reg[LOG2N-1-gi];
      end
      if (BITREV) begin : g_addr_rev
         assign wr_addr = cnt_rev;
      end else begin : g_addr_lin
         assign wr_addr = cnt_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg <= RECV;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         done_reg  <= done_next;
      end
   end

   // cnt has already advanced when ACK completes, so a wrapped count of zero
   // means the sample just acknowledged was the last one of the frame.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      wr_en      = 1'b0;
      case (state_reg)
         RECV: begin
            if (en && req_i) begin
               wr_en      = rstn;
               cnt_next   = cnt_reg + 1'b1;
               state_next = ACK;
            end
         end
         ACK: begin
            if (!req_i) begin
               if (cnt_reg == '0) begin
                  state_next = FULL;
                  done_next  = 1'b1;
               end else begin
                  state_next = RECV;
               end
            end
         end
         FULL: begin
            if (release_i) begin
               state_next = RECV;
            end
         end
         default: begin
            state_next = RECV;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= {data_iR, data_iJ};
      end
   end

   // Read-before-write: a same-cycle write to rd_addr_i is seen one cycle later.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_r_reg <= '0;
         rd_j_reg <= '0;
      end else begin
         {rd_r_reg, rd_j_reg} <= mem[rd_addr_i];
      end
   end

   assign ans_o      = (state_reg == ACK);
   assign req_o      = (state_reg != FULL);
   assign full_o     = (state_reg == FULL);
   assign done_o     = done_reg;
   assign rd_data_oR = rd_r_reg;
   assign rd_data_oJ = rd_j_reg;

endmodule

// File: tb/tb_fft_input.sv
// Randomized directed bench for fft_input: two instances (bit-reversed and linear
// addressing) share stimulus and are checked against a frame-level buffer model.
module tb_fft_input;

   localparam int LOG2N = 3;
   localparam int N     = 1 << LOG2N;
   localparam int DW    = 16;

   logic             clk = 1'b0;
   logic             rstn;
   logic             en;
   logic             req_i;
   logic [DW-1:0]    data_iR, data_iJ;
   logic [LOG2N-1:0] rd_addr_i;
   logic             release_i;

   logic             ans1, req1, done1, full1;
   logic [DW-1:0]    rdr1, rdj1;
   logic             ans0, req0, done0, full0;
   logic [DW-1:0]    rdr0, rdj0;

   int compared   = 0;
   int mismatched = 0;

   logic [2*DW-1:0] model_rev [N];
   logic [2*DW-1:0] model_lin [N];
   int              model_cnt = 0;
   int              sample_no = 0;

   always #5 clk = ~clk;

   fft_input #(.LOG2N(LOG2N), .BITREV(1'b1), .DW(DW)) dut_rev (
      .clk(clk), .rstn(rstn), .en(en), .req_i(req_i),
      .data_iR(data_iR), .data_iJ(data_iJ),
      .ans_o(ans1), .req_o(req1), .done_o(done1), .full_o(full1),
      .rd_addr_i(rd_addr_i), .rd_data_oR(rdr1), .rd_data_oJ(rdj1),
      .release_i(release_i)
   );

   fft_input #(.LOG2N(LOG2N), .BITREV(1'b0), .DW(DW)) dut_lin (
      .clk(clk), .rstn(rstn), .en(en), .req_i(req_i),
      .data_iR(data_iR), .data_iJ(data_iJ),
      .ans_o(ans0), .req_o(req0), .done_o(done0), .full_o(full0),
      .rd_addr_i(rd_addr_i), .rd_data_oR(rdr0), .rd_data_oJ(rdj0),
      .release_i(release_i)
   );

   function automatic int rev(input int k);
      int r = 0;
      for (int b = 0; b < LOG2N; b++) r = r * 2 + ((k >> b) & 1);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic record(input logic [DW-1:0] r, input logic [DW-1:0] j);
      model_rev[rev(model_cnt)] = {r, j};
      model_lin[model_cnt]      = {r, j};
      $display("sample %0d: slot %0d R=%h J=%h", sample_no, model_cnt, r, j);
      model_cnt = (model_cnt + 1) % N;
      sample_no++;
   endtask

   task automatic wait_ans(input logic v, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ans1 !== v && n < 40);
      check(tag, {31'd0, ans1}, {31'd0, v});
      check({tag, "_lin"}, {31'd0, ans0}, {31'd0, v});
   endtask

   task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] j, output logic done_seen);
      req_i   = 1'b1;
      data_iR = r;
      data_iJ = j;
      wait_ans(1'b1, "ans_rise");
      record(r, j);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      req_i = 1'b0;
      wait_ans(1'b0, "ans_fall");
      done_seen = done1;
      check("done_lin_sync", {31'd0, done0}, {31'd0, done_seen === 1'b1 && model_cnt == 0});
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic check_frame_end();
      @(negedge clk);
      check("done_width", {31'd0, done1}, 32'd0);
      check("full_after", {31'd0, full1}, 32'd1);
      check("req_after", {31'd0, req1}, 32'd0);
      check("full_after_lin", {31'd0, full0}, 32'd1);
   endtask

   task automatic read_all();
      for (int a = 0; a < N; a++) begin
         rd_addr_i = LOG2N'(a);
         @(negedge clk);
         check($sformatf("rd_rev[%0d]", a), {rdr1, rdj1}, model_rev[a]);
         check($sformatf("rd_lin[%0d]", a), {rdr0, rdj0}, model_lin[a]);
      end
   endtask

   task automatic random_samples(input int count, input bit pulse_release);
      logic d;
      for (int i = 0; i < count; i++) begin
         if (pulse_release && i == 1) begin
            release_i = 1'b1;
            @(negedge clk);
            release_i = 1'b0;
            check("release_ignored", {31'd0, full1}, 32'd0);
         end
         send(DW'($urandom), DW'($urandom), d);
         check("done_rand", {31'd0, d}, {31'd0, model_cnt == 0});
      end
   endtask

   initial begin
      logic d;
      rstn = 1'b0; en = 1'b1; req_i = 1'b0; data_iR = '0; data_iJ = '0;
      rd_addr_i = '0; release_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ans", {31'd0, ans1}, 32'd0);
      check("rst_done", {31'd0, done1}, 32'd0);
      check("rst_full", {31'd0, full1}, 32'd0);
      check("rst_rd", {rdr1, rdj1}, 32'd0);
      check("rst_rd_lin", {rdr0, rdj0}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      check("rst_req", {31'd0, req1}, 32'd1);

      // Directed frame: R = k, J = -k
      for (int k = 0; k < N; k++) begin
         send(DW'(k), DW'(0) - DW'(k), d);
         check($sformatf("done_k%0d", k), {31'd0, d}, {31'd0, k == N - 1});
      end
      check_frame_end();
      read_all();
      rd_addr_i = 3'd4;
      @(negedge clk);
      check("addr4", {rdr1, rdj1}, 32'h0001_FFFF);
      rd_addr_i = 3'd6;
      @(negedge clk);
      check("addr6_R", {16'd0, rdr1}, 32'd3);
      for (int k = 0; k < N; k++) begin
         rd_addr_i = LOG2N'(k);
         @(negedge clk);
         check($sformatf("lin_R%0d", k), {16'd0, rdr0}, k);
      end

      // Source stalls against a full buffer; release and request together
      req_i   = 1'b1;
      data_iR = 16'h1234;
      data_iJ = DW'($urandom);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("full_stall_ans", {31'd0, ans1}, 32'd0);
         check("full_stall_full", {31'd0, full1}, 32'd1);
      end
      read_all();
      release_i = 1'b1;
      @(negedge clk);
      release_i = 1'b0;
      check("rel_no_capture", {31'd0, ans1}, 32'd0);
      check("rel_full", {31'd0, full1}, 32'd0);
      check("rel_req", {31'd0, req1}, 32'd1);
      @(negedge clk);
      check("rel_capture", {31'd0, ans1}, 32'd1);
      record(data_iR, data_iJ);
      req_i = 1'b0;
      wait_ans(1'b0, "rel_ans_fall");

      // Capture gated by en
      en      = 1'b0;
      req_i   = 1'b1;
      data_iR = DW'($urandom);
      data_iJ = DW'($urandom);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("en_low_ans", {31'd0, ans1}, 32'd0);
      end
      en = 1'b1;
      @(negedge clk);
      check("en_capture", {31'd0, ans1}, 32'd1);
      record(data_iR, data_iJ);
      en    = 1'b0;
      req_i = 1'b0;
      wait_ans(1'b0, "en_ans_fall");
      en = 1'b1;
      check("en_done", {31'd0, done1}, 32'd0);

      random_samples(N - 2, 1'b1);
      check_frame_end();
      read_all();
      release_i = 1'b1;
      @(negedge clk);
      release_i = 1'b0;
      check("release_full", {31'd0, full1}, 32'd0);

      // Reset mid-frame while ans_o is high
      random_samples(4, 1'b0);
      req_i   = 1'b1;
      data_iR = DW'($urandom);
      data_iJ = DW'($urandom);
      wait_ans(1'b1, "pre_rst_ans");
      record(data_iR, data_iJ);
      rstn  = 1'b0;
      req_i = 1'b0;
      @(negedge clk);
      check("midrst_ans", {31'd0, ans1}, 32'd0);
      check("midrst_req", {31'd0, req1}, 32'd1);
      check("midrst_full", {31'd0, full1}, 32'd0);
      check("midrst_rd", {rdr1, rdj1}, 32'd0);
      rstn = 1'b1;
      model_cnt = 0;
      @(negedge clk);
      random_samples(N, 1'b1);
      check_frame_end();
      read_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
